// File: rtl/lcd_timing_ctrl_if.sv
// lcd_timing_ctrl_if: panel-ID/frame inputs and timing/enable outputs of the LCD timing controller
interface lcd_timing_ctrl_if;
   logic [15:0] lcd_id;
   logic        frame_start;
   logic [10:0] h_sync, h_back, h_disp, h_total;
   logic [10:0] v_sync, v_back, v_disp, v_total;
   logic [1:0]  clk_sel;
   logic        cfg_valid, drv_en, disp_en, bl_en, id_err;
   modport master (
      input  lcd_id, frame_start,
      output h_sync, h_back, h_disp, h_total, v_sync, v_back, v_disp, v_total,
      output clk_sel, cfg_valid, drv_en, disp_en, bl_en, id_err
   );
   modport slave (
      output lcd_id, frame_start,
      input  h_sync, h_back, h_disp, h_total, v_sync, v_back, v_disp, v_total,
      input  clk_sel, cfg_valid, drv_en, disp_en, bl_en, id_err
   );
endinterface

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: panel-ID timing decode plus power-up and frame-aligned reconfigure sequencing
module lcd_timing_ctrl #(
   parameter int PWR_CYCLES = 1000,
   parameter int BL_FRAMES  = 2
) (
   input logic               pclk,
   input logic               rst,
   lcd_timing_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, DECODE, PWR_WAIT, BLANK, RUN, RECONF} state_t;
   state_t      state;
   logic [15:0] id_q, cnt;
   logic [3:0]  fcnt;
   logic [90:0] set, cfg;
   // {h sync/back/disp/total, v sync/back/disp/total, clk_sel, id_err}
   always_comb begin
      case (id_q)
         16'h7084: set = {11'd128, 11'd88, 11'd800, 11'd1056, 11'd2, 11'd33, 11'd480, 11'd525, 2'd1, 1'b0};
         16'h7016: set = {11'd20, 11'd140, 11'd1024, 11'd1344, 11'd3, 11'd20, 11'd600, 11'd635, 2'd2, 1'b0};
         16'h1018: set = {11'd10, 11'd80, 11'd1280, 11'd1440, 11'd3, 11'd10, 11'd800, 11'd823, 2'd3, 1'b0};
         default:  set = {11'd41, 11'd2, 11'd480, 11'd525, 11'd10, 11'd2, 11'd272, 11'd286, 2'd0, id_q != 16'h4342};
      endcase
   end
   assign {bus.h_sync, bus.h_back, bus.h_disp, bus.h_total,
           bus.v_sync, bus.v_back, bus.v_disp, bus.v_total, bus.clk_sel, bus.id_err} = cfg;
   always_ff @(posedge pclk) begin
      if (rst) begin
         state         <= IDLE;
         id_q          <= '0;
         cnt           <= '0;
         fcnt          <= '0;
         cfg           <= '0;
         bus.cfg_valid <= 1'b0;
         bus.drv_en    <= 1'b0;
         bus.disp_en   <= 1'b0;
         bus.bl_en     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               id_q  <= bus.lcd_id;
               state <= DECODE;
            end
            DECODE: begin
               cfg           <= set;
               bus.cfg_valid <= 1'b1;
               cnt           <= '0;
               fcnt          <= '0;
               state         <= PWR_WAIT;
            end
            PWR_WAIT: begin
               if (cnt == 16'(PWR_CYCLES - 1)) begin
                  bus.drv_en <= 1'b1;
                  state      <= BLANK;
               end else cnt <= cnt + 16'd1;
            end
            BLANK: begin
               if (bus.frame_start) begin
                  if (fcnt == 4'(BL_FRAMES)) begin
                     bus.disp_en <= 1'b1;
                     bus.bl_en   <= 1'b1;
                     state       <= RUN;
                  end else fcnt <= fcnt + 4'd1;
               end
            end
            RUN: begin
               if (bus.lcd_id != id_q) begin
                  bus.disp_en <= 1'b0;
                  bus.bl_en   <= 1'b0;
                  state       <= RECONF;
               end
            end
            RECONF: begin
               if (bus.frame_start) begin
                  bus.drv_en    <= 1'b0;
                  bus.cfg_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
